sudoku_board_dp: RTL
====================

SUDOKU_BOARD_DP -- requirements
Module: sudoku_board_dp

Interface
REQ-001 Parameters SHALL be, one per line:
- BOX, 2: box side.
- N, BOX*BOX: board side and max digit.
- CELLS, N*N: cell count.
- VW, $clog2(N+1): cell value width.
- IW, $clog2(CELLS): cell index width.
- STRIDE, 5: hint-scatter stride; SHALL be coprime to CELLS.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clka  in  1  sole clock; all state updates on rising edge.
- restart_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 NEW, 01 WRITE, 10 CHECK, 11 CLEAR.
- seed  in  IW  puzzle seed; sampled on NEW.
- difficulty  in  2  00 REVEAL, 01 EASY, 10 MEDIUM, 11 HARD; sampled on NEW.
- cell_idx  in  IW  WRITE target (row-major).
- cell_val  in  VW  WRITE value; 0 = empty.
- user_board  out  CELLS*VW  flat board; cell i at bits [i*VW +: VW].
- given_mask  out  CELLS  1 = locked hint cell.
- busy  out  1  GEN or CHK active.
- done  out  1  one-cycle completion pulse.
- wr_reject  out  1  pulses with done when a WRITE is refused.
- solved  out  1  result of last CHECK.
- err_count  out  IW+1  mismatching cells from last CHECK.

Function
REQ-003 Handshake SHALL be: a command is accepted on an edge where cmd_valid && cmd_ready; cmd_valid is ignored while cmd_ready is low.
REQ-004 FSM states SHALL be IDLE, GEN, CHK, DONE.
REQ-005 FSM transitions SHALL be:
- IDLE->GEN on NEW; IDLE->CHK on CHECK; IDLE->DONE on WRITE or CLEAR.
- GEN and CHK each hold for exactly CELLS cycles, one cell per cycle, index 0..CELLS-1, then go to DONE.
- DONE->IDLE unconditionally; done=1 only in DONE.
REQ-006 Solution value for cell i (r=i/N, c=i%N) SHALL be ((r*BOX + r/BOX + c + seed) mod N) + 1; the solution is internal and never output.
REQ-007 Cell i SHALL be a hint iff ((i*STRIDE + seed) mod CELLS) < H, where H = CELLS for REVEAL, CELLS/2 for EASY, 3*CELLS/8 for MEDIUM, CELLS/4 for HARD.
REQ-008 During GEN, each visited cell SHALL be handled as follows:
- solution stored.
- given bit set to the hint result.
- user cell set to the solution if a hint, else 0.
REQ-009 WRITE SHALL update the user cell on the accept edge unless either condition holds:
- the given bit of cell_idx is set;
- cell_val > N.
Either condition leaves the board unchanged and sets wr_reject=1 in DONE.
REQ-010 CLEAR SHALL zero every non-given user cell on the accept edge.
REQ-011 CHK SHALL compare each user cell i with solution cell i; empty cells count as mismatches.
REQ-012 At DONE after CHK, err_count SHALL equal the mismatch total and solved SHALL be (err_count==0).
REQ-013 solved SHALL clear on acceptance of NEW, WRITE or CLEAR; err_count SHALL hold until the next CHK completes.
REQ-014 Latency SHALL be: NEW/CHECK accepted at edge T give done at cycle T+CELLS+1; WRITE/CLEAR give done at cycle T+1.

Reset
REQ-015 When restart_n is low, the block SHALL asynchronously go to IDLE with the following values:
- cmd_ready 1.
- user_board, given_mask, solution 0.
- busy, done, wr_reject, solved 0.
- err_count 0.
REQ-016 Reset asserted mid-GEN or mid-CHK SHALL abort the operation with no done pulse.

Structure
REQ-017 Package sudoku_pkg SHALL hold:
- op codes, difficulty codes, FSM state enum;
- hint-threshold function;
- solution-value function.
REQ-018 Sub-module sudoku_cell_gen (combinational: index, seed, difficulty -> solution value, hint bit) SHALL be instantiated once and driven by the GEN index counter.

Verification (N=4, seed=0)
REQ-019 Reset, then NEW EASY accepted at T -> done at T+17; given_mask bits 0,1,4 =1 and bits 2,3,5 =0; popcount(given_mask)=8; cell0=1; cell2=0.
REQ-020 WRITE idx0 val3 -> wr_reject=1, cell0 stays 1; WRITE idx2 val5 -> wr_reject=1; WRITE idx2 val3 -> cell2=3, wr_reject=0.
REQ-021 After a fresh NEW EASY, CHECK -> solved=0, err_count=8; after correct writes to all 8 free cells, CHECK -> solved=1, err_count=0; then CLEAR -> free cells 0, solved=0.
REQ-022 NEW REVEAL then CHECK -> solved=1, err_count=0; user row0 = 1,2,3,4; row1 = 3,4,1,2.
REQ-023 restart_n low 5 cycles into GEN -> all outputs at reset values, no done pulse; cmd_valid with CHECK held during GEN -> not accepted until cmd_ready=1.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku board datapath.
// Holds command and difficulty codes, FSM state constants, and the two pure
// functions that define a puzzle: the per-cell solution value and the hint
// threshold for a given difficulty.
package sudoku_pkg;

   // Command op codes
   localparam logic [1:0] OpNew   = 2'b00;
   localparam logic [1:0] OpWrite = 2'b01;
   localparam logic [1:0] OpCheck = 2'b10;
   localparam logic [1:0] OpClear = 2'b11;

   // Difficulty codes
   localparam logic [1:0] DiffReveal = 2'b00;
   localparam logic [1:0] DiffEasy   = 2'b01;
   localparam logic [1:0] DiffMedium = 2'b10;
   localparam logic [1:0] DiffHard   = 2'b11;

   // FSM states
   typedef logic [1:0] state_t;
   localparam state_t StIdle = 2'd0;
   localparam state_t StGen  = 2'd1;
   localparam state_t StChk  = 2'd2;
   localparam state_t StDone = 2'd3;

   // Number of hint slots; a cell is a hint when its scattered rank is below this.
   function automatic int unsigned hint_thresh(input int unsigned cells, input logic [1:0] diff);
      int unsigned h;
      case (diff)
         DiffReveal: h = cells;
         DiffEasy:   h = cells / 2;
         DiffMedium: h = (3 * cells) / 8;
         default:    h = cells / 4;
      endcase
      return h;
   endfunction

   // Shifted-row Latin pattern: row r starts at r*box + r/box, so every row,
   // column and box holds each digit once.
   function automatic int unsigned sol_value(input int unsigned idx, input int unsigned seed,
                                             input int unsigned box, input int unsigned n);
      int unsigned r;
      int unsigned c;
      r = idx / n;
      c = idx % n;
      return ((r * box + r / box + c + seed) % n) + 1;
   endfunction

endpackage

// File: rtl/sudoku_cell_gen.sv
// Combinational per-cell puzzle generator.
// Ports:
//   idx_i        cell index (row-major)
//   seed_i       puzzle seed
//   difficulty_i difficulty code
//   sol_o        solution digit for the cell (1..N)
//   hint_o       1 when the cell is a locked hint
module sudoku_cell_gen import sudoku_pkg::*; #(
   parameter int unsigned BOX    = 2,
   parameter int unsigned N      = BOX * BOX,
   parameter int unsigned CELLS  = N * N,
   parameter int unsigned VW     = $clog2(N + 1),
   parameter int unsigned IW     = $clog2(CELLS),
   parameter int unsigned STRIDE = 5
) (
   input  logic [IW-1:0] idx_i,
   input  logic [IW-1:0] seed_i,
   input  logic [1:0]    difficulty_i,
   output logic [VW-1:0] sol_o,
   output logic          hint_o
);

   always_comb begin
      sol_o  = VW'(sol_value(32'(idx_i), 32'(seed_i), BOX, N));
      // STRIDE coprime to CELLS makes this a permutation, so exactly H cells are hints.
      hint_o = ((32'(idx_i) * STRIDE + 32'(seed_i)) % CELLS) < hint_thresh(CELLS, difficulty_i);
   end

endmodule

// File: rtl/sudoku_board_dp.sv
// Sudoku board datapath: generates a seeded puzzle, accepts user writes,
// clears free cells and checks the user board against the hidden solution.
// Ports:
//   clka, restart_n           clock, async active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only when idle)
//   cmd_op                    NEW / WRITE / CHECK / CLEAR
//   seed, difficulty          puzzle parameters, sampled on NEW
//   cell_idx, cell_val        WRITE target and value (0 = empty)
//   user_board, given_mask    board contents and locked-hint mask
//   busy, done, wr_reject     status; done pulses one cycle per command
//   solved, err_count         result of the last CHECK
module sudoku_board_dp import sudoku_pkg::*; #(
   parameter int unsigned BOX    = 2,
   parameter int unsigned N      = BOX * BOX,
   parameter int unsigned CELLS  = N * N,
   parameter int unsigned VW     = $clog2(N + 1),
   parameter int unsigned IW     = $clog2(CELLS),
   parameter int unsigned STRIDE = 5
) (
   input  logic                clka,
   input  logic                restart_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [IW-1:0]       seed,
   input  logic [1:0]          difficulty,
   input  logic [IW-1:0]       cell_idx,
   input  logic [VW-1:0]       cell_val,
   output logic [CELLS*VW-1:0] user_board,
   output logic [CELLS-1:0]    given_mask,
   output logic                busy,
   output logic                done,
   output logic                wr_reject,
   output logic                solved,
   output logic [IW:0]         err_count
);

   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [IW-1:0]       seed_q, seed_d;
   logic [1:0]          diff_q, diff_d;
   logic [CELLS*VW-1:0] user_q, user_d;
   logic [CELLS*VW-1:0] sol_q, sol_d;
   logic [CELLS-1:0]    given_q, given_d;
   logic                wr_rej_q, wr_rej_d;
   logic                solved_q, solved_d;
   logic [IW:0]         err_count_q, err_count_d;
   logic [IW:0]         err_acc_q, err_acc_d;

   logic [VW-1:0]       gen_sol;
   logic                gen_hint;
   logic [VW-1:0]       cur_user;
   logic [VW-1:0]       cur_sol;
   logic                mismatch;
   logic                last_cell;

   sudoku_cell_gen #(
      .BOX    (BOX),
      .N      (N),
      .CELLS  (CELLS),
      .VW     (VW),
      .IW     (IW),
      .STRIDE (STRIDE)
   ) u_cell_gen (
      .idx_i        (idx_q),
      .seed_i       (seed_q),
      .difficulty_i (diff_q),
      .sol_o        (gen_sol),
      .hint_o       (gen_hint)
   );

   assign last_cell = (idx_q == IW'(CELLS - 1));
   assign cur_user  = user_q[32'(idx_q) * VW +: VW];
   assign cur_sol   = sol_q[32'(idx_q) * VW +: VW];
   // Empty cells never match, even against an unloaded (all-zero) solution.
   assign mismatch  = (cur_user == '0) || (cur_user != cur_sol);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      seed_d      = seed_q;
      diff_d      = diff_q;
      user_d      = user_q;
      sol_d       = sol_q;
      given_d     = given_q;
      wr_rej_d    = wr_rej_q;
      solved_d    = solved_q;
      err_count_d = err_count_q;
      err_acc_d   = err_acc_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               unique case (cmd_op)
                  OpNew: begin
                     state_d  = StGen;
                     idx_d    = '0;
                     seed_d   = seed;
                     diff_d   = difficulty;
                     solved_d = 1'b0;
                  end
                  OpCheck: begin
                     state_d   = StChk;
                     idx_d     = '0;
                     err_acc_d = '0;
                  end
                  OpWrite: begin
                     state_d  = StDone;
                     solved_d = 1'b0;
                     if (given_q[cell_idx] || (cell_val > VW'(N))) begin
                        wr_rej_d = 1'b1;
                     end else begin
                        user_d[32'(cell_idx) * VW +: VW] = cell_val;
                     end
                  end
                  OpClear: begin
                     state_d  = StDone;
                     solved_d = 1'b0;
                     for (int i = 0; i < int'(CELLS); i++) begin
                        if (!given_q[i]) begin
                           user_d[i * VW +: VW] = '0;
                        end
                     end
                  end
                  default: state_d = StIdle;
               endcase
            end
         end
         StGen: begin
            sol_d[32'(idx_q) * VW +: VW]  = gen_sol;
            given_d[idx_q]                = gen_hint;
            user_d[32'(idx_q) * VW +: VW] = gen_hint ? gen_sol : '0;
            idx_d                         = idx_q + 1'b1;
            if (last_cell) begin
               state_d = StDone;
            end
         end
         StChk: begin
            err_acc_d = err_acc_q + (IW + 1)'(mismatch);
            idx_d     = idx_q + 1'b1;
            if (last_cell) begin
               err_count_d = err_acc_d;
               solved_d    = (err_acc_d == '0);
               state_d     = StDone;
            end
         end
         StDone: begin
            state_d  = StIdle;
            wr_rej_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         seed_q      <= '0;
         diff_q      <= '0;
         user_q      <= '0;
         sol_q       <= '0;
         given_q     <= '0;
         wr_rej_q    <= 1'b0;
         solved_q    <= 1'b0;
         err_count_q <= '0;
         err_acc_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         seed_q      <= seed_d;
         diff_q      <= diff_d;
         user_q      <= user_d;
         sol_q       <= sol_d;
         given_q     <= given_d;
         wr_rej_q    <= wr_rej_d;
         solved_q    <= solved_d;
         err_count_q <= err_count_d;
         err_acc_q   <= err_acc_d;
      end
   end

   assign cmd_ready  = (state_q == StIdle);
   assign busy       = (state_q == StGen) || (state_q == StChk);
   assign done       = (state_q == StDone);
   // Set only on the WRITE accept edge and cleared on leaving DONE.
   assign wr_reject  = wr_rej_q;
   assign solved     = solved_q;
   assign err_count  = err_count_q;
   assign user_board = user_q;
   assign given_mask = given_q;

endmodule
